red_pitaya_bus_sequencer: RTL and testbench

//  Bus initiator for the DSP system bus: replays a programmed table of register

---
 rtl/red_pitaya_bus_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_red_pitaya_bus_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_bus_sequencer.sv
// Table-driven bus initiator: replays programmed WRITE/READ/WAIT/END commands
// onto the DSP system bus after a start pulse.
module red_pitaya_bus_sequencer #(
    parameter int LOG_DEPTH   = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_wen,
    input  logic [LOG_DEPTH+1:0] cfg_addr,
    input  logic [31:0]          cfg_wdata,
    input  logic                 start_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [31:0]          rd_data_o,
    output logic [LOG_DEPTH-1:0] pc_o,
    output logic [31:0]          m_sys_addr,
    output logic [31:0]          m_sys_wdata,
    output logic [3:0]           m_sys_sel,
    output logic                 m_sys_wen,
    output logic                 m_sys_ren,
    input  logic [31:0]          m_sys_rdata,
    input  logic                 m_sys_ack,
    input  logic                 m_sys_err
);

    localparam int DEPTH = 2 ** LOG_DEPTH;
    localparam int TO_W  = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [TO_W-1:0]      TO_LAST = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [LOG_DEPTH-1:0] LAST_PC = LOG_DEPTH'(DEPTH - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_ISSUE    = 3'd2;
    localparam logic [2:0] S_WAIT_ACK = 3'd3;
    localparam logic [2:0] S_DELAY    = 3'd4;
    localparam logic [2:0] S_FINISH   = 3'd5;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WAIT  = 2'd2;
    localparam logic [1:0] OP_END   = 2'd3;

    logic [1:0]  r_tbl_op   [DEPTH];
    logic [31:0] r_tbl_addr [DEPTH];
    logic [31:0] r_tbl_data [DEPTH];

    logic [2:0]           r_state;
    logic [LOG_DEPTH-1:0] r_pc;
    logic [1:0]           r_op;
    logic [15:0]          r_dly;
    logic [TO_W-1:0]      r_to_cnt;
    logic                 r_busy;
    logic                 r_err;
    logic [31:0]          r_rd_data;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;

    logic [LOG_DEPTH-1:0] w_cfg_entry;
    logic [1:0]           w_cfg_field;
    logic                 w_last;
    logic [2:0]           w_adv_state;
    logic [LOG_DEPTH-1:0] w_adv_pc;

    assign w_cfg_entry = cfg_addr[LOG_DEPTH+1:2];
    assign w_cfg_field = cfg_addr[1:0];

    // Table RAM is never reset; software reloads it as needed.
    always_ff @(posedge clk_i) begin
        if (cfg_wen) begin
            case (w_cfg_field)
                2'd0:    r_tbl_op[w_cfg_entry]   <= cfg_wdata[1:0];
                2'd1:    r_tbl_addr[w_cfg_entry] <= cfg_wdata;
                2'd2:    r_tbl_data[w_cfg_entry] <= cfg_wdata;
                default: ;
            endcase
        end
    end

    // The last table entry acts as an implicit END; the pc never wraps.
    assign w_last      = (r_pc == LAST_PC);
    assign w_adv_state = w_last ? S_FINISH : S_FETCH;
    assign w_adv_pc    = w_last ? r_pc : r_pc + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_op      <= OP_WRITE;
            r_dly     <= '0;
            r_to_cnt  <= '0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_rd_data <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else if (abort_i && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i && !abort_i) begin
                        r_state <= S_FETCH;
                        r_pc    <= '0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b0 | 1'b1;
                    end
                end
                S_FETCH: begin
                    r_op    <= r_tbl_op[r_pc];
                    r_dly   <= r_tbl_data[r_pc][15:0];
                    r_state <= S_ISSUE;
                    // Bus address/data only change for real requests, so they
                    // stay stable between consecutive bus transactions.
                    if (r_tbl_op[r_pc] == OP_WRITE || r_tbl_op[r_pc] == OP_READ) begin
                        r_addr <= r_tbl_addr[r_pc];
                    end
                    if (r_tbl_op[r_pc] == OP_WRITE) begin
                        r_wdata <= r_tbl_data[r_pc];
                    end
                end
                S_ISSUE: begin
                    case (r_op)
                        OP_WRITE, OP_READ: begin
                            r_to_cnt <= '0;
                            r_state  <= S_WAIT_ACK;
                        end
                        OP_WAIT: r_state <= S_DELAY;
                        default: r_state <= S_FINISH;
                    endcase
                end
                S_WAIT_ACK: begin
                    if (m_sys_ack) begin
                        if (m_sys_err) begin
                            r_err   <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            if (r_op == OP_READ) begin
                                r_rd_data <= m_sys_rdata;
                            end
                            r_pc    <= w_adv_pc;
                            r_state <= w_adv_state;
                        end
                    end else if (r_to_cnt == TO_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                S_DELAY: begin
                    if (r_dly == 16'd0) begin
                        r_pc    <= w_adv_pc;
                        r_state <= w_adv_state;
                    end else begin
                        r_dly <= r_dly - 16'd1;
                    end
                end
                S_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bus handshake: a request is the single-cycle wen/ren pulse in ISSUE with
    // addr/wdata valid; the responder completes it with ack (err qualifies it)
    // on any later cycle, and only an ack seen during WAIT_ACK is consumed.
    assign m_sys_wen   = (r_state == S_ISSUE) && (r_op == OP_WRITE);
    assign m_sys_ren   = (r_state == S_ISSUE) && (r_op == OP_READ);
    assign m_sys_sel   = m_sys_wen ? 4'hF : 4'h0;
    assign m_sys_addr  = r_addr;
    assign m_sys_wdata = r_wdata;

    assign done_o    = (r_state == S_FINISH) && !abort_i;
    assign busy_o    = r_busy;
    assign err_o     = r_err;
    assign rd_data_o = r_rd_data;
    assign pc_o      = r_pc;

endmodule

// File: tb/tb_red_pitaya_bus_sequencer.sv
// Directed bench for red_pitaya_bus_sequencer: programs command tables, plays a
// simple bus responder and checks bus traffic, timing and status outputs.
module tb_red_pitaya_bus_sequencer;

    localparam logic [1:0] OP_W   = 2'd0;
    localparam logic [1:0] OP_R   = 2'd1;
    localparam logic [1:0] OP_DLY = 2'd2;
    localparam logic [1:0] OP_END = 2'd3;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        cfg_wen = 1'b0;
    logic [5:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        busy_o, done_o, err_o;
    logic [31:0] rd_data_o;
    logic [3:0]  pc_o;
    logic [31:0] m_sys_addr, m_sys_wdata;
    logic [3:0]  m_sys_sel;
    logic        m_sys_wen, m_sys_ren;
    logic [31:0] m_sys_rdata = '0;
    logic        m_sys_ack = 1'b0;
    logic        m_sys_err = 1'b0;

    red_pitaya_bus_sequencer #(.LOG_DEPTH(4), .ACK_TIMEOUT(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cfg_wen(cfg_wen), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .start_i(start_i), .abort_i(abort_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .rd_data_o(rd_data_o), .pc_o(pc_o),
        .m_sys_addr(m_sys_addr), .m_sys_wdata(m_sys_wdata), .m_sys_sel(m_sys_sel),
        .m_sys_wen(m_sys_wen), .m_sys_ren(m_sys_ren),
        .m_sys_rdata(m_sys_rdata), .m_sys_ack(m_sys_ack), .m_sys_err(m_sys_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Scoreboard: expected write transactions in issue order.
    logic [31:0] exp_q[$];
    logic [31:0] exp_data_q[$];

    int done_cyc, done_cnt, wen_cnt, wen_extra, ren_cnt, ren_cyc, bad_cnt;
    logic [31:0] busy_c1, pc_c1, err_c1, post_rst_nz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input int entry, input int field, input logic [31:0] data);
        cfg_addr  = 6'((entry << 2) | field);
        cfg_wdata = data;
        cfg_wen   = 1'b1;
        @(posedge clk); #1;
        cfg_wen   = 1'b0;
    endtask

    task automatic set_entry(input int entry, input logic [1:0] op,
                             input logic [31:0] addr, input logic [31:0] data);
        cfg_write(entry, 0, {30'd0, op});
        cfg_write(entry, 1, addr);
        cfg_write(entry, 2, data);
    endtask

    task automatic push_wr(input logic [31:0] addr, input logic [31:0] data);
        exp_q.push_back(addr);
        exp_data_q.push_back(data);
    endtask

    // Start a run and observe max_cyc cycles; cycle 1 is the one after the start edge.
    task automatic run(input int max_cyc, input int n_acks, input logic [31:0] rdata_v,
                       input logic err_v, input int restart_cyc, input int abort_cyc,
                       input int late_ack_cyc, input int rst_cyc);
        int   acks_given;
        logic nxt, nxt_err;
        acks_given = 0;
        done_cyc = -1; done_cnt = 0; wen_cnt = 0; wen_extra = 0;
        ren_cnt = 0; ren_cyc = -1; bad_cnt = 0; post_rst_nz = '0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (c == 1) begin
                busy_c1 = 32'(busy_o);
                pc_c1   = 32'(pc_o);
                err_c1  = 32'(err_o);
            end
            if (c == rst_cyc + 1) begin
                post_rst_nz = 32'(busy_o | done_o | err_o | (|rd_data_o) | (|pc_o) |
                                  (|m_sys_addr) | (|m_sys_wdata) | (|m_sys_sel) |
                                  m_sys_wen | m_sys_ren);
            end
            if (m_sys_wen) begin
                wen_cnt++;
                if (exp_q.size() == 0) begin
                    wen_extra++;
                end else begin
                    check("wen_addr", m_sys_addr, exp_q.pop_front());
                    check("wen_data", m_sys_wdata, exp_data_q.pop_front());
                end
            end
            if (m_sys_ren) begin
                ren_cnt++;
                if (ren_cyc < 0) ren_cyc = c;
            end
            if (m_sys_wen && m_sys_ren) bad_cnt++;
            if (m_sys_sel !== (m_sys_wen ? 4'hF : 4'h0)) bad_cnt++;
            if (done_o) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            nxt = 1'b0;
            nxt_err = 1'b0;
            if ((m_sys_wen || m_sys_ren) && acks_given < n_acks) begin
                nxt = 1'b1;
                nxt_err = err_v;
                acks_given++;
            end
            if (c + 1 == late_ack_cyc) nxt = 1'b1;
            @(posedge clk); #1;
            m_sys_ack   = nxt;
            m_sys_err   = nxt_err;
            m_sys_rdata = nxt ? rdata_v : 32'h0;
            start_i     = (c + 1 == restart_cyc);
            abort_i     = (c + 1 == abort_cyc);
            rst_i       = (c + 1 == rst_cyc);
        end
        m_sys_ack = 1'b0; m_sys_err = 1'b0; m_sys_rdata = '0;
        start_i = 1'b0; abort_i = 1'b0; rst_i = 1'b0;
        @(negedge clk);
        check("wen_extra", 32'(wen_extra), 32'd0);
        check("exp_left", 32'(exp_q.size()), 32'd0);
        check("bus_protocol", 32'(bad_cnt), 32'd0);
        exp_q.delete();
        exp_data_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_pc", 32'(pc_o), 32'd0);
        check("rst_rd_data", rd_data_o, 32'd0);
        check("rst_bus", {m_sys_addr[15:0] | m_sys_wdata[15:0], 10'd0, m_sys_sel,
                          m_sys_wen, m_sys_ren}, 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;

        // Two writes then END, 1-cycle ack
        set_entry(0, OP_W, 32'h40300000, 32'h0000000A);
        set_entry(1, OP_W, 32'h40310004, 32'h00000002);
        set_entry(2, OP_END, 32'h0, 32'h0);
        push_wr(32'h40300000, 32'h0000000A);
        push_wr(32'h40310004, 32'h00000002);
        run(12, 99, 32'h0, 1'b0, 0, 0, 0, 0);
        check("t1_busy_c1", busy_c1, 32'd1);
        check("t1_wen_cnt", 32'(wen_cnt), 32'd2);
        check("t1_done_cyc", 32'(done_cyc), 32'd9);
        check("t1_done_cnt", 32'(done_cnt), 32'd1);
        check("t1_err", 32'(err_o), 32'd0);
        check("t1_busy_end", 32'(busy_o), 32'd0);
        check("t1_pc", 32'(pc_o), 32'd2);
        check("t1_addr_hold", m_sys_addr, 32'h40310004);

        // Read returns 3
        set_entry(0, OP_R, 32'h40300008, 32'h0);
        set_entry(1, OP_END, 32'h0, 32'h0);
        run(10, 99, 32'h00000003, 1'b0, 0, 0, 0, 0);
        check("t2_rd_data", rd_data_o, 32'h00000003);
        check("t2_wen_cnt", 32'(wen_cnt), 32'd0);
        check("t2_ren_cnt", 32'(ren_cnt), 32'd1);
        check("t2_done_cyc", 32'(done_cyc), 32'd6);
        check("t2_pc", 32'(pc_o), 32'd1);
        check("t2_addr", m_sys_addr, 32'h40300008);

        // Responder error on the read: err set, rd_data kept
        run(10, 99, 32'hDEADBEEF, 1'b1, 0, 0, 0, 0);
        check("t2e_err", 32'(err_o), 32'd1);
        check("t2e_done_cyc", 32'(done_cyc), 32'd4);
        check("t2e_rd_data", rd_data_o, 32'h00000003);
        check("t2e_pc", 32'(pc_o), 32'd0);

        // No ack: timeout after 4 WAIT_ACK cycles
        run(12, 0, 32'h0, 1'b0, 0, 0, 0, 0);
        check("t3_err_c1", err_c1, 32'd0);
        check("t3_err", 32'(err_o), 32'd1);
        check("t3_ren_cyc", 32'(ren_cyc), 32'd2);
        check("t3_done_after_ren", 32'(done_cyc - ren_cyc), 32'd5);
        check("t3_done_cnt", 32'(done_cnt), 32'd1);
        check("t3_pc", 32'(pc_o), 32'd0);
        check("t3_rd_data", rd_data_o, 32'h00000003);

        // WAIT 0, WAIT 5 (upper data bits ignored), END; restart while busy ignored
        set_entry(0, OP_DLY, 32'h0, 32'h12340000);
        set_entry(1, OP_DLY, 32'h0, 32'hABCD0005);
        set_entry(2, OP_END, 32'h0, 32'h0);
        run(25, 99, 32'h0, 1'b0, 5, 0, 0, 0);
        check("t4_done_cyc", 32'(done_cyc), 32'd14);
        check("t4_done_cnt", 32'(done_cnt), 32'd1);
        check("t4_bus_idle", 32'(wen_cnt + ren_cnt), 32'd0);
        check("t4_err", 32'(err_o), 32'd0);
        check("t4_pc", 32'(pc_o), 32'd2);

        // Abort during second write's WAIT_ACK, late ack afterwards
        set_entry(0, OP_W, 32'h40300010, 32'h00000055);
        set_entry(1, OP_W, 32'h40300014, 32'h00000066);
        set_entry(2, OP_END, 32'h0, 32'h0);
        push_wr(32'h40300010, 32'h00000055);
        push_wr(32'h40300014, 32'h00000066);
        run(14, 1, 32'h0, 1'b0, 0, 7, 9, 0);
        check("t5_done_cnt", 32'(done_cnt), 32'd0);
        check("t5_wen_cnt", 32'(wen_cnt), 32'd2);
        check("t5_busy", 32'(busy_o), 32'd0);
        check("t5_err", 32'(err_o), 32'd0);
        push_wr(32'h40300010, 32'h00000055);
        push_wr(32'h40300014, 32'h00000066);
        run(12, 99, 32'h0, 1'b0, 0, 0, 0, 0);
        check("t5_pc_c1", pc_c1, 32'd0);
        check("t5_rerun_done_cyc", 32'(done_cyc), 32'd9);
        check("t5_rerun_pc", 32'(pc_o), 32'd2);

        // Full table of writes, no END: implicit finish at last entry
        for (int i = 0; i < 16; i++) begin
            set_entry(i, OP_W, 32'h40320000 + 32'(i * 4), 32'(i * 17 + 1));
            push_wr(32'h40320000 + 32'(i * 4), 32'(i * 17 + 1));
        end
        run(60, 99, 32'h0, 1'b0, 0, 0, 0, 0);
        check("t6_wen_cnt", 32'(wen_cnt), 32'd16);
        check("t6_done_cyc", 32'(done_cyc), 32'd49);
        check("t6_done_cnt", 32'(done_cnt), 32'd1);
        check("t6_pc", 32'(pc_o), 32'd15);
        check("t6_err", 32'(err_o), 32'd0);

        // Reset during the third write's ISSUE cycle
        for (int i = 0; i < 3; i++) begin
            push_wr(32'h40320000 + 32'(i * 4), 32'(i * 17 + 1));
        end
        run(20, 99, 32'h0, 1'b0, 0, 0, 0, 8);
        check("t6r_outputs_zero", post_rst_nz, 32'd0);
        check("t6r_wen_cnt", 32'(wen_cnt), 32'd3);
        check("t6r_done_cnt", 32'(done_cnt), 32'd0);
        check("t6r_busy", 32'(busy_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
